// File: rtl/sargantana_icache_pkg.sv
// Shared icache constants and types.
// Holds the array geometry, the L2 beat count and the refill FSM state encoding.
package sargantana_icache_pkg;

  localparam int unsigned N_WAY      = 4;
  localparam int unsigned WAY_IDX_W  = $clog2(N_WAY);
  localparam int unsigned TAG_W      = 20;
  localparam int unsigned IDX_W      = 6;
  localparam int unsigned LINE_W     = 512;
  localparam int unsigned BEAT_W     = 128;
  localparam int unsigned N_BEATS    = LINE_W / BEAT_W;
  localparam int unsigned BEAT_CNT_W = $clog2(N_BEATS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    FILL  = 2'd2,
    WRITE = 2'd3
  } refill_state_t;

endpackage

// File: rtl/sargantana_icache_victim_sel.sv
// Victim way selection for refills.
// Picks the lowest-index invalid way, or the round-robin pointer when the set is full.
// Ports: clk, rst_n; valid (way valid bits of the set); update (a write used
// the current choice); victim_c (one-hot victim, combinational).
module sargantana_icache_victim_sel
  import sargantana_icache_pkg::*;
#(
  parameter int unsigned WAYS = N_WAY
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [WAYS-1:0] valid,
  input  logic            update,
  output logic [WAYS-1:0] victim_c
);

  localparam int unsigned PTR_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  logic [PTR_W-1:0] rr_q;
  logic [PTR_W-1:0] free_idx;
  logic [WAYS-1:0]  free;
  logic             any_free;

  // Trailing-zero style priority encode of the free ways: scanning downwards
  // leaves the lowest free index in free_idx.
  always_comb begin
    free     = ~valid;
    any_free = |free;
    free_idx = '0;
    for (int i = int'(WAYS) - 1; i >= 0; i--) begin
      if (free[i]) free_idx = PTR_W'(i);
    end
    victim_c = WAYS'(1) << (any_free ? free_idx : rr_q);
  end

  // Pointer only moves when a write actually consumed it (set was full).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q <= '0;
    end else if (update && !any_free) begin
      rr_q <= rr_q + PTR_W'(1);
    end
  end

endmodule

// File: rtl/sargantana_icache_refill.sv
// Icache refill unit: takes one miss, requests the line from L2, assembles the
// beats and writes tag/valid/line into the victim way in a single cycle.
// Ports: miss_* (miss handshake from icache control), kill_i (abort),
// l2_req_* (line request), l2_rsp_* (response beats, no backpressure),
// wr_* (array write port), done_o / err_o (completion pulses).
module sargantana_icache_refill
  import sargantana_icache_pkg::*;
(
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              miss_valid_i,
  output logic              miss_ready_o,
  input  logic [TAG_W-1:0]  miss_tag_i,
  input  logic [IDX_W-1:0]  miss_idx_i,
  input  logic [N_WAY-1:0]  set_valid_i,
  input  logic              kill_i,
  output logic              l2_req_valid_o,
  input  logic              l2_req_ready_i,
  output logic [TAG_W-1:0]  l2_req_tag_o,
  output logic [IDX_W-1:0]  l2_req_idx_o,
  input  logic              l2_rsp_valid_i,
  input  logic [BEAT_W-1:0] l2_rsp_data_i,
  input  logic              l2_rsp_err_i,
  output logic              wr_en_o,
  output logic [N_WAY-1:0]  wr_way_o,
  output logic [IDX_W-1:0]  wr_idx_o,
  output logic [TAG_W-1:0]  wr_tag_o,
  output logic [LINE_W-1:0] wr_data_o,
  output logic              done_o,
  output logic              err_o
);

  refill_state_t          state_q;
  logic [BEAT_CNT_W-1:0]  cnt_q;
  logic [TAG_W-1:0]       tag_q;
  logic [IDX_W-1:0]       idx_q;
  logic [N_WAY-1:0]       set_valid_q;
  logic [LINE_W-1:0]      line_q;
  logic                   kill_q;
  logic                   err_q;
  logic                   kill_next;
  logic                   err_next;
  logic                   last_beat;
  logic [N_WAY-1:0]       victim;

  // Flags including the current cycle, so a kill/error on the last beat counts.
  assign kill_next = kill_q | kill_i;
  assign err_next  = err_q | (l2_rsp_valid_i & l2_rsp_err_i);
  assign last_beat = l2_rsp_valid_i && (cnt_q == BEAT_CNT_W'(N_BEATS - 1));

  // Captured miss doubles as the request address and the write address.
  assign l2_req_tag_o = tag_q;
  assign l2_req_idx_o = idx_q;
  assign wr_tag_o     = tag_q;
  assign wr_idx_o     = idx_q;
  assign wr_data_o    = line_q;

  sargantana_icache_victim_sel #(
    .WAYS(N_WAY)
  ) u_victim_sel (
    .clk     (clk_i),
    .rst_n   (rstn_i),
    .valid   (set_valid_q),
    .update  (wr_en_o),
    .victim_c(victim)
  );

  // Refill FSM with registered outputs.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      tag_q          <= '0;
      idx_q          <= '0;
      set_valid_q    <= '0;
      line_q         <= '0;
      kill_q         <= 1'b0;
      err_q          <= 1'b0;
      miss_ready_o   <= 1'b1;
      l2_req_valid_o <= 1'b0;
      wr_en_o        <= 1'b0;
      wr_way_o       <= '0;
      done_o         <= 1'b0;
      err_o          <= 1'b0;
    end else begin
      wr_en_o  <= 1'b0;
      wr_way_o <= '0;
      done_o   <= 1'b0;
      err_o    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (miss_valid_i) begin
            tag_q          <= miss_tag_i;
            idx_q          <= miss_idx_i;
            set_valid_q    <= set_valid_i;
            miss_ready_o   <= 1'b0;
            l2_req_valid_o <= 1'b1;
            state_q        <= REQ;
          end
        end
        REQ: begin
          // A handshake already seen by L2 must be drained, so a kill in the
          // same cycle only marks the fill as killed.
          if (l2_req_ready_i) begin
            l2_req_valid_o <= 1'b0;
            cnt_q          <= '0;
            kill_q         <= kill_i;
            state_q        <= FILL;
          end else if (kill_i) begin
            l2_req_valid_o <= 1'b0;
            miss_ready_o   <= 1'b1;
            state_q        <= IDLE;
          end
        end
        FILL: begin
          kill_q <= kill_next;
          err_q  <= err_next;
          if (l2_rsp_valid_i) begin
            line_q[cnt_q*BEAT_W +: BEAT_W] <= l2_rsp_data_i;
            cnt_q <= cnt_q + BEAT_CNT_W'(1);
          end
          if (last_beat) begin
            state_q <= WRITE;
            if (!kill_next && !err_next) begin
              wr_en_o  <= 1'b1;
              wr_way_o <= victim;
              done_o   <= 1'b1;
            end else if (!kill_next) begin
              err_o <= 1'b1;
            end
          end
        end
        WRITE: begin
          kill_q       <= 1'b0;
          err_q        <= 1'b0;
          cnt_q        <= '0;
          miss_ready_o <= 1'b1;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Beats are only legal while a fill is outstanding.
  stray_beat_a: assert property (@(posedge clk_i) disable iff (!rstn_i)
    l2_rsp_valid_i |-> (state_q == FILL));

endmodule

// File: tb/tb_sargantana_icache_refill.sv
module tb_sargantana_icache_refill;
  import sargantana_icache_pkg::*;

  logic              clk_i = 1'b0;
  logic              rstn_i;
  logic              miss_valid_i;
  logic              miss_ready_o;
  logic [TAG_W-1:0]  miss_tag_i;
  logic [IDX_W-1:0]  miss_idx_i;
  logic [N_WAY-1:0]  set_valid_i;
  logic              kill_i;
  logic              l2_req_valid_o;
  logic              l2_req_ready_i;
  logic [TAG_W-1:0]  l2_req_tag_o;
  logic [IDX_W-1:0]  l2_req_idx_o;
  logic              l2_rsp_valid_i;
  logic [BEAT_W-1:0] l2_rsp_data_i;
  logic              l2_rsp_err_i;
  logic              wr_en_o;
  logic [N_WAY-1:0]  wr_way_o;
  logic [IDX_W-1:0]  wr_idx_o;
  logic [TAG_W-1:0]  wr_tag_o;
  logic [LINE_W-1:0] wr_data_o;
  logic              done_o;
  logic              err_o;

  sargantana_icache_refill dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .miss_valid_i(miss_valid_i), .miss_ready_o(miss_ready_o),
    .miss_tag_i(miss_tag_i), .miss_idx_i(miss_idx_i), .set_valid_i(set_valid_i),
    .kill_i(kill_i),
    .l2_req_valid_o(l2_req_valid_o), .l2_req_ready_i(l2_req_ready_i),
    .l2_req_tag_o(l2_req_tag_o), .l2_req_idx_o(l2_req_idx_o),
    .l2_rsp_valid_i(l2_rsp_valid_i), .l2_rsp_data_i(l2_rsp_data_i),
    .l2_rsp_err_i(l2_rsp_err_i),
    .wr_en_o(wr_en_o), .wr_way_o(wr_way_o), .wr_idx_o(wr_idx_o),
    .wr_tag_o(wr_tag_o), .wr_data_o(wr_data_o),
    .done_o(done_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  // kind: 0 = normal write, 1 = error, 2 = killed (no output at all)
  typedef struct {
    logic [TAG_W-1:0] tag;
    logic [IDX_W-1:0] idx;
    logic [N_WAY-1:0] sv;
    int               stall;
    int               gap;
    int               err_beat;
    int               kill_beat;
    bit               kill_req;
    logic [N_WAY-1:0] exp_way;
    int               kind;
  } vec_t;

  typedef struct {
    int                kind;
    logic [N_WAY-1:0]  way;
    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag;
    logic [LINE_W-1:0] line;
  } exp_t;

  localparam int N_VEC = 14;
  vec_t vecs [N_VEC];
  exp_t sb [$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard side: any write/done/err activity must match the oldest expectation.
  task automatic monitor();
    exp_t e;
    if (wr_en_o || done_o || err_o || (|wr_way_o)) begin
      if (sb.size() == 0) begin
        chk("unexpected_output", {wr_en_o, done_o, err_o, wr_way_o}, '0);
      end else begin
        e = sb.pop_front();
        chk("wr_en", wr_en_o, (e.kind == 0));
        chk("done", done_o, (e.kind == 0));
        chk("err", err_o, (e.kind == 1));
        chk("wr_way", wr_way_o, e.way);
        if (e.kind == 0) begin
          chk("wr_idx", wr_idx_o, e.idx);
          chk("wr_tag", wr_tag_o, e.tag);
          chk("wr_data", wr_data_o, e.line);
        end
      end
    end
  endtask

  task automatic at_neg();
    @(negedge clk_i);
    monitor();
  endtask

  task automatic at_pos();
    @(posedge clk_i);
    #1;
  endtask

  task automatic step();
    at_neg();
    at_pos();
  endtask

  task automatic run_vec(input int vi, input vec_t v);
    exp_t        e;
    logic [BEAT_W-1:0] beat;
    logic [3:0]  nib;
    e.kind = v.kind;
    e.way  = v.exp_way;
    e.idx  = v.idx;
    e.tag  = v.tag;
    e.line = '0;
    miss_valid_i = 1'b1;
    miss_tag_i   = v.tag;
    miss_idx_i   = v.idx;
    set_valid_i  = v.sv;
    at_neg();
    chk("miss_ready_idle", miss_ready_o, 1'b1);
    at_pos();
    miss_valid_i = 1'b0;
    miss_tag_i   = '0;
    miss_idx_i   = '0;
    set_valid_i  = '0;
    for (int s = 0; s < v.stall; s++) begin
      at_neg();
      chk("req_held", l2_req_valid_o, 1'b1);
      chk("req_tag_stable", l2_req_tag_o, v.tag);
      chk("req_idx_stable", l2_req_idx_o, v.idx);
      chk("miss_ready_busy", miss_ready_o, 1'b0);
      at_pos();
    end
    if (v.kill_req) begin
      kill_i = 1'b1;
      at_neg();
      chk("req_before_kill", l2_req_valid_o, 1'b1);
      at_pos();
      kill_i = 1'b0;
      at_neg();
      chk("kill_req_valid", l2_req_valid_o, 1'b0);
      chk("kill_req_ready", miss_ready_o, 1'b1);
      at_pos();
      return;
    end
    l2_req_ready_i = 1'b1;
    at_neg();
    chk("req_valid", l2_req_valid_o, 1'b1);
    chk("req_tag", l2_req_tag_o, v.tag);
    chk("req_idx", l2_req_idx_o, v.idx);
    at_pos();
    l2_req_ready_i = 1'b0;
    for (int k = 0; k < int'(N_BEATS); k++) begin
      for (int g = 0; g < v.gap; g++) step();
      if (vi == 0) begin
        nib  = 4'(10 + k);
        beat = {32{nib}};
      end else begin
        beat = {$urandom(), $urandom(), $urandom(), $urandom()};
      end
      e.line[k*BEAT_W +: BEAT_W] = beat;
      l2_rsp_valid_i = 1'b1;
      l2_rsp_data_i  = beat;
      l2_rsp_err_i   = (k == v.err_beat);
      kill_i         = (k == v.kill_beat);
      at_neg();
      chk("no_early_write", wr_en_o, 1'b0);
      at_pos();
      l2_rsp_valid_i = 1'b0;
      l2_rsp_data_i  = '0;
      l2_rsp_err_i   = 1'b0;
      kill_i         = 1'b0;
    end
    if (v.kind != 2) sb.push_back(e);
    // Write cycle: the monitor pops the expectation here.
    at_neg();
    chk("write_cycle_wr_en", wr_en_o, (v.kind == 0));
    chk("write_cycle_err", err_o, (v.kind == 1));
    chk("sb_drained", 32'(sb.size()), 32'd0);
    at_pos();
    at_neg();
    chk("miss_ready_after", miss_ready_o, 1'b1);
    chk("pulse_cleared", {wr_en_o, done_o, err_o}, 3'b000);
    at_pos();
  endtask

  task automatic reset_mid_fill();
    miss_valid_i = 1'b1;
    miss_tag_i   = 20'hCCCCC;
    miss_idx_i   = 6'd13;
    set_valid_i  = 4'b1111;
    step();
    miss_valid_i   = 1'b0;
    l2_req_ready_i = 1'b1;
    step();
    l2_req_ready_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      l2_rsp_valid_i = 1'b1;
      l2_rsp_data_i  = {4{32'hFEED0000 + 32'(k)}};
      step();
    end
    l2_rsp_valid_i = 1'b0;
    l2_rsp_data_i  = '0;
    #2 rstn_i = 1'b0;
    #1;
    chk("rst_miss_ready", miss_ready_o, 1'b1);
    chk("rst_req_valid", l2_req_valid_o, 1'b0);
    chk("rst_pulses", {wr_en_o, done_o, err_o}, 3'b000);
    chk("rst_wr_way", wr_way_o, '0);
    chk("rst_wr_data", wr_data_o, '0);
    at_neg();
    at_pos();
    rstn_i = 1'b1;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    //           tag       idx    sv       stl gap err kil kreq way      kind
    vecs[0]  = '{20'h12345, 6'd5,  4'b0000, 0, 0, -1, -1, 0, 4'b0001, 0};
    vecs[1]  = '{20'h0ABCD, 6'd9,  4'b1011, 0, 0, -1, -1, 0, 4'b0100, 0};
    vecs[2]  = '{20'h11111, 6'd1,  4'b1111, 0, 0, -1, -1, 0, 4'b0001, 0};
    vecs[3]  = '{20'h22222, 6'd2,  4'b1111, 0, 0, -1, -1, 0, 4'b0010, 0};
    vecs[4]  = '{20'h33333, 6'd3,  4'b1111, 3, 2, -1, -1, 0, 4'b0100, 0};
    vecs[5]  = '{20'h44444, 6'd4,  4'b1111, 0, 0,  2, -1, 0, 4'b0000, 1};
    vecs[6]  = '{20'h55555, 6'd7,  4'b1111, 0, 1, -1, -1, 0, 4'b1000, 0};
    vecs[7]  = '{20'h66666, 6'd8,  4'b1111, 0, 0, -1,  1, 0, 4'b0000, 2};
    vecs[8]  = '{20'h77777, 6'd63, 4'b1111, 0, 0, -1, -1, 0, 4'b0001, 0};
    vecs[9]  = '{20'h88888, 6'd0,  4'b0111, 0, 0, -1, -1, 0, 4'b1000, 0};
    vecs[10] = '{20'h99999, 6'd10, 4'b1110, 1, 0, -1, -1, 0, 4'b0001, 0};
    vecs[11] = '{20'hAAAAA, 6'd11, 4'b0000, 1, 0, -1, -1, 1, 4'b0000, 2};
    vecs[12] = '{20'hBBBBB, 6'd12, 4'b1111, 0, 0, -1, -1, 0, 4'b0010, 0};
    // Applied after the mid-fill reset: pointer must be back at way 0.
    vecs[13] = '{20'hDDDDD, 6'd14, 4'b1111, 0, 0, -1, -1, 0, 4'b0001, 0};

    rstn_i = 1'b0;
    miss_valid_i = 1'b0; miss_tag_i = '0; miss_idx_i = '0; set_valid_i = '0;
    kill_i = 1'b0; l2_req_ready_i = 1'b0;
    l2_rsp_valid_i = 1'b0; l2_rsp_data_i = '0; l2_rsp_err_i = 1'b0;
    #12;
    chk("reset_miss_ready", miss_ready_o, 1'b1);
    chk("reset_req_valid", l2_req_valid_o, 1'b0);
    chk("reset_pulses", {wr_en_o, done_o, err_o}, 3'b000);
    chk("reset_wr_way", wr_way_o, '0);
    chk("reset_wr_data", wr_data_o, '0);
    at_pos();
    rstn_i = 1'b1;
    // A kill while idle must not disturb anything.
    kill_i = 1'b1;
    step();
    kill_i = 1'b0;
    at_neg();
    chk("idle_kill_ready", miss_ready_o, 1'b1);
    chk("idle_kill_req", l2_req_valid_o, 1'b0);
    at_pos();

    for (int i = 0; i < N_VEC; i++) begin
      if (i == 13) reset_mid_fill();
      run_vec(i, vecs[i]);
    end
    repeat (3) step();
    chk("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
